// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop jump controller.
package riscv_hwloop_pkg;

    localparam int unsigned HWLP_ADDR_W   = 32;
    // Smallest counter value at which the end instruction loops back.
    localparam int unsigned HWLP_TAKE_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hwlp_state_e;

    // Index width for a loop count, never narrower than one bit.
    function automatic int unsigned hwlp_sel_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_hwloop_jump_ctrl_if.sv
// ID / loop-register / fetch signals seen by the hwloop jump controller.
interface riscv_hwloop_jump_ctrl_if
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS = 2
);

    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_start_addr_i;
    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_end_addr_i;
    logic [N_REGS-1:0][HWLP_ADDR_W-1:0] hwlp_counter_i;
    logic [HWLP_ADDR_W-1:0]             pc_i;
    logic                               pc_valid_i;
    logic                               instr_done_i;
    logic                               flush_i;
    logic                               jump_ack_i;
    logic [N_REGS-1:0]                  hwlp_dec_cnt_o;
    logic                               jump_req_o;
    logic [HWLP_ADDR_W-1:0]             jump_target_o;
    logic                               id_kill_o;

    // Controller side.
    modport slave (
        input  hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
        input  pc_i, pc_valid_i, instr_done_i, flush_i, jump_ack_i,
        output hwlp_dec_cnt_o, jump_req_o, jump_target_o, id_kill_o
    );

    // Environment side (ID stage, loop registers, fetch).
    modport master (
        output hwlp_start_addr_i, hwlp_end_addr_i, hwlp_counter_i,
        output pc_i, pc_valid_i, instr_done_i, flush_i, jump_ack_i,
        input  hwlp_dec_cnt_o, jump_req_o, jump_target_o, id_kill_o
    );

endinterface

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address comparators with lowest-index priority select.
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS     = 2,
    parameter int unsigned N_REG_BITS = hwlp_sel_bits(N_REGS)
) (
    input  logic [HWLP_ADDR_W-1:0]             i_pc,
    input  logic                               i_pc_valid,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] i_end_addr,
    input  logic [N_REGS-1:0][HWLP_ADDR_W-1:0] i_counter,
    output logic                               o_hit_c,
    output logic [N_REG_BITS-1:0]              o_sel_c,
    output logic [N_REGS-1:0]                  o_sel_onehot_c,
    output logic                               o_take_c
);

    logic [N_REGS-1:0] w_hit_vec;

    // A loop hits when it is still active and ID holds its last instruction.
    always_comb begin
        w_hit_vec = '0;
        for (int k = 0; k < int'(N_REGS); k++) begin
            w_hit_vec[k] = i_pc_valid && (i_pc == i_end_addr[k]) && (i_counter[k] != '0);
        end
    end

    // Lowest index wins; scanning downward lets the lowest hit overwrite the rest.
    always_comb begin
        o_hit_c = 1'b0;
        o_sel_c = '0;
        for (int k = int'(N_REGS) - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) begin
                o_hit_c = 1'b1;
                o_sel_c = N_REG_BITS'(k);
            end
        end
        o_sel_onehot_c = o_hit_c ? (N_REGS'(1) << o_sel_c) : '0;
        o_take_c       = o_hit_c && (i_counter[o_sel_c] >= HWLP_ADDR_W'(HWLP_TAKE_MIN));
    end

endmodule

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop jump controller: decrements the selected loop counter and
// requests a loop-back jump from fetch, holding it until acknowledged.
// Optional macro RISCV_HWLP_FAST_JUMP_EN adds a combinational zero-bubble
// jump path while idle.
module riscv_hwloop_jump_ctrl
    import riscv_hwloop_pkg::*;
#(
    parameter int unsigned N_REGS = 2
) (
    input logic                       clk,
    input logic                       rst_n,
    riscv_hwloop_jump_ctrl_if.slave   bus
);

    localparam int unsigned N_REG_BITS = hwlp_sel_bits(N_REGS);

    hwlp_state_e            r_state;
    logic [HWLP_ADDR_W-1:0] r_target;
    logic                   r_jump_req;
    logic                   r_id_kill;

    logic                   w_hit;
    logic [N_REG_BITS-1:0]  w_sel;
    logic [N_REGS-1:0]      w_sel_onehot;
    logic                   w_take;
    logic [HWLP_ADDR_W-1:0] w_start_sel;
    logic                   w_loop_back;

    riscv_hwloop_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match (
        .i_pc           (bus.pc_i),
        .i_pc_valid     (bus.pc_valid_i),
        .i_end_addr     (bus.hwlp_end_addr_i),
        .i_counter      (bus.hwlp_counter_i),
        .o_hit_c        (w_hit),
        .o_sel_c        (w_sel),
        .o_sel_onehot_c (w_sel_onehot),
        .o_take_c       (w_take)
    );

    assign w_start_sel = bus.hwlp_start_addr_i[w_sel];
    assign w_loop_back = bus.instr_done_i && w_take;

    // Jump FSM with registered request, kill and target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_target   <= '0;
            r_jump_req <= 1'b0;
            r_id_kill  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_loop_back) begin
                        r_target <= w_start_sel;
`ifdef RISCV_HWLP_FAST_JUMP_EN
                        // Fetch took the combinational request already.
                        if (!bus.jump_ack_i) begin
                            r_state    <= PEND;
                            r_jump_req <= 1'b1;
                            r_id_kill  <= 1'b1;
                        end
`else
                        r_state    <= PEND;
                        r_jump_req <= 1'b1;
                        r_id_kill  <= 1'b1;
`endif
                    end
                end
                PEND: begin
                    // A flush redirect supersedes the loop-back in fetch.
                    if (bus.jump_ack_i || bus.flush_i) begin
                        r_state    <= IDLE;
                        r_jump_req <= 1'b0;
                        r_id_kill  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_jump_req <= 1'b0;
                    r_id_kill  <= 1'b0;
                end
            endcase
        end
    end

    // Decrement is only meaningful while no loop-back is outstanding.
    assign bus.hwlp_dec_cnt_o = ((r_state == IDLE) && w_hit) ? w_sel_onehot : '0;
    assign bus.id_kill_o      = r_id_kill;

`ifdef RISCV_HWLP_FAST_JUMP_EN
    // Idle: expose the loop-back combinationally for a zero-bubble jump.
    assign bus.jump_req_o    = r_jump_req || ((r_state == IDLE) && w_loop_back);
    assign bus.jump_target_o = (r_state == IDLE) ? w_start_sel : r_target;
`else
    assign bus.jump_req_o    = r_jump_req;
    assign bus.jump_target_o = r_target;
`endif

endmodule

// File: doc/riscv_hwloop_jump_ctrl.md
# riscv_hwloop_jump_ctrl

Consumer side of the hardware-loop register file. It watches the instruction in ID against the loop end addresses and counters. When a loop body ends it issues a one-hot decrement back to the loop registers and a jump request to the fetch stage, and it holds that request until fetch acknowledges it. It sits between the ID stage, the hwloop registers and the prefetch/fetch unit.

## Interface
- N_REGS, 2, number of hardware loops (loop 0 is the innermost).
- N_REG_BITS, $clog2(N_REGS), loop index width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous, active-low reset.
- hwlp_start_addr_i  in  N_REGS×32  loop start addresses.
- hwlp_end_addr_i  in  N_REGS×32  loop end addresses (address of the last instruction of the body).
- hwlp_counter_i  in  N_REGS×32  remaining iterations.
- pc_i  in  32  PC of the instruction in ID.
- pc_valid_i  in  1  pc_i holds a real instruction.
- instr_done_i  in  1  the instruction at pc_i leaves ID this cycle; this is the same signal as the registers' valid_i.
- flush_i  in  1  branch, exception or debug redirect; kills any pending jump.
- jump_ack_i  in  1  fetch accepts the jump target.
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement to the loop registers.
- jump_req_o  out  1  loop-back request to fetch.
- jump_target_o  out  32  loop-back address.
- id_kill_o  out  1  instruction in ID is wrong-path and must not execute.

## Operation
- Loop k is active when hwlp_counter_i[k] != 0. Loop k hits when pc_valid_i && pc_i == hwlp_end_addr_i[k] && loop k is active.
- sel = lowest-index hit. Several loops hitting the same end address is illegal in software; lowest index wins and the others are untouched.
- Decrement: hwlp_dec_cnt_o = onehot(sel) when a hit exists and state == IDLE, else 0. The registers apply it only on instr_done_i, so at most one bit is set per cycle and there is exactly one decrement per completed end instruction.
- Take: hit && hwlp_counter_i[sel] >= 2 (unsigned compare). When the counter is 1, the loop decrements to 0 and falls through with no jump.
- State machine:
  - IDLE -> PEND on instr_done_i && take; capture start[sel] into target_q.
  - PEND -> IDLE on jump_ack_i or flush_i.
  - flush_i in IDLE: no effect on the state; decrement gating is unchanged, since the regs still use instr_done_i.
- PEND outputs: jump_req_o = 1, jump_target_o = target_q, id_kill_o = 1, hwlp_dec_cnt_o = 0. The prefetched instructions past the end address are wrong-path.
- IDLE outputs: jump_req_o = 0, id_kill_o = 0, jump_target_o = target_q (stale, don't-care).
- Simultaneous jump_ack_i and flush_i in PEND: go to IDLE; the flush redirect has priority in fetch.

## Timing
- Reset values: state IDLE, target_q 0, jump_req_o 0, jump_target_o 0, id_kill_o 0. hwlp_dec_cnt_o is 0 unless a hit occurs.
- hwlp_dec_cnt_o is combinational from inputs and state, with zero latency.
- Without the fast path, jump_req_o rises the cycle after the end instruction completes. It then stays high for a minimum of 1 cycle and until jump_ack_i.
- Reset asserted while in PEND returns to IDLE at the next clk edge, and the request is dropped.

## Configuration
- RISCV_HWLP_FAST_JUMP_EN defined: in IDLE, jump_req_o = instr_done_i && take and jump_target_o = start[sel], both combinational.
  - If jump_ack_i is high in the same cycle, stay in IDLE, giving zero bubbles.
  - Otherwise enter PEND as normal.
- RISCV_HWLP_FAST_JUMP_EN undefined: outputs are registered only, with a one-cycle loop-back penalty.

## Structure
- Package riscv_hwloop_pkg holds:
  - the hwlp_state_e enum (IDLE, PEND);
  - HWLP_TAKE_MIN = 2.
- Sub-module riscv_hwloop_match, per-loop comparators plus lowest-index priority select. Its outputs are hit, sel (N_REG_BITS), sel_onehot and take.

## Test plan
- Single loop: start=0x100, end=0x10C, cnt=3. Complete 0x10C three times.
  - Two jumps to 0x100.
  - dec_cnt=01 on every completion.
  - Third pass (cnt=1) falls through with no jump_req.
- Nested loops: loop0 end=0x120 with cnt=2, loop1 end=0x140 with cnt=2.
  - PC 0x120 selects loop0 only; 0x140 selects loop1 only.
  - hwlp_dec_cnt_o is never multi-hot.
- Fetch backpressure: jump_ack_i held low for 4 cycles.
  - jump_req_o and target 0x100 remain stable.
  - id_kill_o stays high and dec stays 0.
  - One cycle after ack, state is IDLE.
- Flush in PEND: flush_i raised on the 2nd PEND cycle returns to IDLE next cycle, and jump_req_o drops.
- Stall in ID: pc=end with instr_done_i low for 3 cycles.
  - dec_cnt asserted but the counter does not move.
  - Exactly one jump after done.
- Macro on: end instruction completes with jump_ack_i=1 in the same cycle. jump_req_o is high that cycle, target equals start, and PEND is never entered.
